// File: rtl/dmem_arbiter.sv
// Two-requester arbiter (CPU M-stage, external master) for the single-port synchronous data RAM.
// Optional DMEM_ARBITER_PERF_EN adds saturating stall/EXT-grant performance counters.
module dmem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int RAM_AW     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [31:0]       ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_wren,
  output logic [RAM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_q,
`ifdef DMEM_ARBITER_PERF_EN
  output logic [15:0]       perf_stall_cnt,
  output logic [15:0]       perf_ext_cnt,
`endif
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CPU_RD = 2'd1;
  localparam logic [1:0] EXT_RD = 2'd2;
  localparam logic [1:0] WR     = 2'd3;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0]        state, state_nxt;
  logic [3:0]        starve_cnt;
  logic              cpu_win, ext_win;
  logic [DATA_W-1:0] ext_rdata_q;

  // Handshake: ext_req is held with stable addr/data until ext_gnt; the
  // transfer completes at the edge where ext_gnt=1. The CPU side has no
  // ready: cpu_stall=1 means the request was not taken this cycle.
  always_comb begin
    cpu_win  = 1'b0;
    ext_win  = 1'b0;
    mem_wren = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    if (reset) begin
      cpu_win = cpu_req & (~ext_req | (starve_cnt != STARVE_LIM));
      ext_win = ext_req & ~cpu_win;
      if (cpu_win) begin
        mem_wren = cpu_we;
        mem_addr = cpu_addr[RAM_AW+1:2];
        mem_data = cpu_wdata;
      end else if (ext_win) begin
        mem_wren = ext_we;
        mem_addr = ext_addr[RAM_AW+1:2];
        mem_data = ext_wdata;
      end
    end
  end

  assign cpu_stall = reset & cpu_req & ~cpu_win;
  assign ext_gnt   = ext_win;

  always_comb begin
    state_nxt = IDLE;
    if (cpu_win)      state_nxt = cpu_we ? WR : CPU_RD;
    else if (ext_win) state_nxt = ext_we ? WR : EXT_RD;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      ext_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (!ext_req || ext_win)
        starve_cnt <= '0;
      else if (cpu_win && starve_cnt != STARVE_LIM)
        starve_cnt <= starve_cnt + 4'd1;
      if (state == EXT_RD)
        ext_rdata_q <= mem_q;
    end
  end

  // The EXT read word is visible in its rvalid cycle and held from then on.
  assign cpu_rdata  = mem_q;
  assign cpu_rvalid = (state == CPU_RD);
  assign ext_rvalid = (state == EXT_RD);
  assign ext_rdata  = (state == EXT_RD) ? mem_q : ext_rdata_q;
  assign dbg_state  = state;

`ifdef DMEM_ARBITER_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cnt <= '0;
      perf_ext_cnt   <= '0;
    end else begin
      if (cpu_stall && perf_stall_cnt != 16'hFFFF)
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
      if (ext_gnt && perf_ext_cnt != 16'hFFFF)
        perf_ext_cnt <= perf_ext_cnt + 16'd1;
    end
  end
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[31:RAM_AW+2], cpu_addr[1:0],
                              ext_addr[31:RAM_AW+2], ext_addr[1:0]};

endmodule
